monolith_hash_arbiter: RTL and testbench

Round-robin scheduler that shares one `monolith_hash` core among `N_REQ` independent requesters. It accepts one hash or compress job at a time over a per-requester valid/ready handshake and builds the 16-lane input state. It sequences the core through clear, launch and wait phases, then returns the 31-bit digest with the originating requester ID. A watchdog aborts jobs whose core never reports `out_valid`.

---
 rtl/monolith_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/monolith_hash_arbiter.sv | 164 ++++++++++++++++
 tb/tb_monolith_hash_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monolith_pkg.sv
// Shared types for the monolith hash arbiter slice: field element width,
// core state layout and the arbiter FSM encoding.
package monolith_pkg;

  localparam int unsigned WIDTH       = 31;
  localparam int unsigned STATE_LANES = 16;

  typedef logic [WIDTH-1:0] felem_t;
  typedef felem_t state_t [STATE_LANES];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W:0]   idx;

  // Scan N positions starting at ptr; the first asserted request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N)) begin
        idx = idx - (PTR_W+1)'(N);
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/monolith_hash_arbiter.sv
// Shares one monolith_hash core among N_REQ requesters: round-robin grant,
// core clear/launch/wait sequencing, watchdog abort and held response.
module monolith_hash_arbiter
  import monolith_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  felem_t [N_REQ-1:0]     req_in1,
  input  felem_t [N_REQ-1:0]     req_in2,
  input  logic [N_REQ-1:0]       req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   core_reset,
  output state_t                 core_state_in,
  output logic                   core_in_valid,
  input  state_t                 core_state_out,
  input  logic                   core_out_valid
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  felem_t            in1_q, in1_d;
  felem_t            in2_q, in2_d;
  logic              mode_q, mode_d;
  logic [ID_W-1:0]   id_q, id_d;
  felem_t            data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   win_idx;
  logic              unused_lanes;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant into the winner index.
  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        win_idx = ID_W'(k);
      end
    end
  end

  // Only lane 0 of the core output carries the digest.
  always_comb begin
    unused_lanes = 1'b0;
    for (int unsigned l = 1; l < STATE_LANES; l++) begin
      unused_lanes = unused_lanes ^ (^core_state_out[l]);
    end
  end

  // Next-state logic: grant/capture, core sequencing, watchdog, response hold.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    mode_d   = mode_q;
    id_d     = id_q;
    data_d   = data_q;
    err_d    = err_q;
    wdog_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          in1_d    = req_in1[win_idx];
          in2_d    = req_in2[win_idx];
          mode_d   = req_mode[win_idx];
          id_d     = win_idx;
          rr_ptr_d = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR:  state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        wdog_d = wdog_q + CNT_W'(1);
        // A result arriving on the timeout cycle still counts as success.
        if (core_out_valid) begin
          data_d  = core_state_out[0];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == TIMEOUT_C) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      mode_q   <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      mode_q   <= mode_d;
      id_q     <= id_d;
      data_q   <= data_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Handshake and core control outputs, forced to reset values during reset.
  always_comb begin
    req_ready     = (state_q == ST_IDLE && !reset) ? grant : '0;
    rsp_valid     = (state_q == ST_RESP) && !reset;
    rsp_data      = data_q;
    rsp_id        = id_q;
    rsp_err       = err_q;
    core_in_valid = (state_q == ST_LAUNCH) && !reset;
    core_reset    = reset || !(state_q == ST_LAUNCH || state_q == ST_WAIT);
  end

  // Core input state built from the captured operands.
  always_comb begin
    for (int unsigned l = 0; l < STATE_LANES; l++) begin
      core_state_in[l] = '0;
    end
    core_state_in[0] = in1_q;
    core_state_in[1] = mode_q ? in2_q : '0;
  end

endmodule

// File: tb/tb_monolith_hash_arbiter.sv
// Directed bench for monolith_hash_arbiter with a stub core and a response
// scoreboard filled at grant time and drained on the response handshake.
module tb_monolith_hash_arbiter;
  import monolith_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  felem_t [N-1:0]  req_in1;
  felem_t [N-1:0]  req_in2;
  logic [N-1:0]    req_mode;
  logic            rsp_valid;
  logic            rsp_ready;
  felem_t          rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_err;
  logic            core_reset;
  state_t          core_state_in;
  logic            core_in_valid;
  state_t          core_state_out;
  logic            core_out_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] id;
    felem_t     data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   last_hs_cyc = 0;
  logic stub_mute = 1'b0;
  exp_t e_push;
  exp_t e_pop;

  // Stub core: result = lane0 + 1, out_valid 11 cycles after the launch cycle.
  int     stub_cnt  = 0;
  logic   stub_busy = 1'b0;
  felem_t stub_val  = '0;

  monolith_hash_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_in1        (req_in1),
    .req_in2        (req_in2),
    .req_mode       (req_mode),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_id         (rsp_id),
    .rsp_err        (rsp_err),
    .core_reset     (core_reset),
    .core_state_in  (core_state_in),
    .core_in_valid  (core_in_valid),
    .core_state_out (core_state_out),
    .core_out_valid (core_out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (core_reset) begin
      stub_busy <= 1'b0;
    end else if (core_in_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 10;
      stub_val  <= core_state_in[0] + 31'd1;
    end else if (stub_busy && stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign core_out_valid = stub_busy && (stub_cnt == 0) && !stub_mute;

  always_comb begin
    for (int l = 0; l < int'(STATE_LANES); l++) core_state_out[l] = '0;
    core_state_out[0] = stub_val;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: push expected result at each grant, compare at each response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          e_push.id   = 2'(i);
          e_push.data = stub_mute ? '0 : req_in1[i] + 31'd1;
          e_push.err  = stub_mute;
          sb.push_back(e_push);
        end
      end
      if (rsp_valid && rsp_ready) begin
        last_hs_cyc = cyc;
        chk("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          chk("sb_rsp_id", 64'(rsp_id), 64'(e_pop.id));
          chk("sb_rsp_data", 64'(rsp_data), 64'(e_pop.data));
          chk("sb_rsp_err", 64'(rsp_err), 64'(e_pop.err));
        end
      end
    end
  end

  task automatic do_req(input int i, input felem_t a, input felem_t b, input logic m,
                        output int gcyc);
    @(posedge clk); #1;
    req_in1[i]   = a;
    req_in2[i]   = b;
    req_mode[i]  = m;
    req_valid[i] = 1'b1;
    gcyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        gcyc = cyc;
        break;
      end
    end
    chk("grant_seen", 64'(req_ready[i]), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int rise);
    rise = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rise = cyc;
        break;
      end
    end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int     g, rise, gc, n0, nwait;
    logic   ok;
    logic   stable;
    logic [3:0] mask;
    felem_t d0;
    logic [1:0] id0;
    logic   err0;

    reset = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; req_mode = '0;
    rsp_ready = 1'b1;
    req_valid[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_core_in_valid", 64'(core_in_valid), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_state_in0", 64'(core_state_in[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;

    // Single hash job from requester 2.
    do_req(2, 31'h5, 31'h0, 1'b0, g);
    @(negedge clk);
    @(negedge clk);
    ok = 1'b1;
    for (int l = 1; l < int'(STATE_LANES); l++) if (core_state_in[l] !== '0) ok = 1'b0;
    chk("hash_upper_lanes_zero", 64'(ok), 64'd1);
    chk("hash_lane0", 64'(core_state_in[0]), 64'h5);
    wait_rsp(rise);
    chk("hash_latency", 64'(rise - g), 64'd14);
    chk("hash_rsp_data", 64'(rsp_data), 64'h6);

    // Compress job from requester 1.
    do_req(1, 31'h11, 31'h22, 1'b1, g);
    @(negedge clk);
    chk("cmp_clear_core_reset", 64'(core_reset), 64'd1);
    chk("cmp_clear_in_valid", 64'(core_in_valid), 64'd0);
    @(negedge clk);
    chk("cmp_launch_in_valid", 64'(core_in_valid), 64'd1);
    chk("cmp_launch_core_reset", 64'(core_reset), 64'd0);
    chk("cmp_launch_lane1", 64'(core_state_in[1]), 64'h22);
    chk("cmp_launch_lane0", 64'(core_state_in[0]), 64'h11);
    ok = 1'b1;
    nwait = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (core_in_valid !== 1'b0 || core_reset !== 1'b0 || core_state_in[1] !== 31'h22) ok = 1'b0;
      nwait++;
    end
    chk("cmp_wait_core_ctl", 64'(ok), 64'd1);
    chk("cmp_wait_len", 64'(nwait), 64'd11);
    chk("cmp_resp_core_reset", 64'(core_reset), 64'd1);

    // Timeout: core never answers.
    stub_mute = 1'b1;
    do_req(2, 31'h77, 31'h0, 1'b0, g);
    wait_rsp(rise);
    chk("to_latency", 64'(rise - g), 64'd24);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_data", 64'(rsp_data), 64'd0);
    @(posedge clk); #1;
    stub_mute = 1'b0;
    wait_drain();

    // Fairness from a fresh pointer: all requesters held valid.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      req_in1[i] = 31'h100 + 31'(i);
      req_mode[i] = 1'b0;
    end
    n0 = grant_log.size();
    req_valid = '1;
    for (int k = 0; k < 400 && grant_log.size() < n0 + 5; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    chk("fair_count", 64'(grant_log.size() >= n0 + 5), 64'd1);
    if (grant_log.size() >= n0 + 5) begin
      for (int j = 0; j < 5; j++) chk("fair_order", 64'(grant_log[n0+j]), 64'(j % 4));
      for (int j = 0; j < 2; j++) begin
        mask = '0;
        for (int w = 0; w < 4; w++) mask[grant_log[n0+j+w]] = 1'b1;
        chk("fair_window", 64'(mask), 64'hF);
      end
    end
    wait_drain();

    // Back-pressure: response held for 50 cycles with a competing request.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req(3, 31'h1234, 31'h0, 1'b0, g);
    req_in1[0] = 31'h55;
    req_mode[0] = 1'b0;
    req_valid[0] = 1'b1;
    wait_rsp(rise);
    d0 = rsp_data; id0 = rsp_id; err0 = rsp_err;
    chk("bp_data", 64'(d0), 64'h1235);
    chk("bp_id", 64'(id0), 64'd3);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== id0 ||
          rsp_err !== err0 || req_ready !== '0) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    gc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        gc = cyc;
        break;
      end
    end
    chk("bp_next_grant", 64'(gc - last_hs_cyc), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;

    // Reset in WAIT of requester 0's job (pointer now at 1).
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    req_in1[0] = 31'h99;
    req_in1[1] = 31'hAA;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_mid_grant", 64'(req_ready), 64'b0001);
    chk("rst_mid_core_reset", 64'(core_reset), 64'd1);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(rise);
    chk("rst_mid_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_mid_rsp_data", 64'(rsp_data), 64'h9A);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
